prog_lut_sweep: RTL and testbench

Programmable N-input boolean function: a 2**N_IN-bit truth table, loaded serially, replaces a fixed mux/gate function with a registered output. A built-in sweep engine walks every input combination in ascending order, which the design previously did only by hand in a testbench. During the sweep it captures the evaluated truth table and counts minterms. It sits beside gate-level function blocks as a reference and self-check model.

---
 rtl/prog_lut_sweep_pkg.sv | 10 +
 rtl/prog_lut_sweep_if.sv | 25 ++
 rtl/prog_lut_sweep_mux.sv | 22 ++
 rtl/prog_lut_sweep.sv | 112 +++++++++++
 tb/tb_prog_lut_sweep.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/prog_lut_sweep_pkg.sv
// Shared definitions for the programmable LUT with a built-in sweep engine.
package prog_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/prog_lut_sweep_if.sv
// Config, evaluation and sweep-result signals of prog_lut_sweep.
interface prog_lut_sweep_if #(parameter int N_IN = 4);
  localparam int TT_W = 1 << N_IN;

  logic              cfg_en;
  logic              cfg_bit;
  logic [N_IN-1:0]   in_vec;
  logic              sweep_start;
  logic              out;
  logic              sweep_busy;
  logic              sweep_done;
  logic [N_IN-1:0]   sweep_vec;
  logic [TT_W-1:0]   sweep_sig;
  logic [N_IN:0]     ones_cnt;

  modport master (
    output cfg_en, cfg_bit, in_vec, sweep_start,
    input  out, sweep_busy, sweep_done, sweep_vec, sweep_sig, ones_cnt
  );

  modport slave (
    input  cfg_en, cfg_bit, in_vec, sweep_start,
    output out, sweep_busy, sweep_done, sweep_vec, sweep_sig, ones_cnt
  );
endinterface

// File: rtl/prog_lut_sweep_mux.sv
// Binary 2:1 mux tree selecting tt[sel]; level l is steered by sel[l].
module lut_mux #(
  parameter int SEL_W = 4
) (
  input  logic [(1<<SEL_W)-1:0] tt,
  input  logic [SEL_W-1:0]      sel,
  output logic                  y
);
  localparam int W = 1 << SEL_W;

  // Each level folds pairs into the low half of v, so v[0] ends as the root.
  always_comb begin : tree
    logic [W-1:0] v;
    v = tt;
    for (int l = 0; l < SEL_W; l++) begin
      for (int i = 0; i < (W >> (l + 1)); i++) begin
        v[i] = sel[l] ? v[2*i+1] : v[2*i];
      end
    end
    y = v[0];
  end
endmodule

// File: rtl/prog_lut_sweep.sv
// Serially loaded N-input truth table with registered output and an
// automatic ascending sweep that captures the table and its minterm count.
module prog_lut_sweep
  import prog_lut_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  prog_lut_sweep_if.slave  bus
);
  localparam int TT_W = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(TT_W - 1);

  state_e            state_q, state_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [TT_W-1:0]   sig_work_q, sig_work_d;
  logic [TT_W-1:0]   sweep_sig_q, sweep_sig_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]   sweep_vec_q, sweep_vec_d;
  logic [N_IN:0]     acc_q, acc_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN-1:0]   sel;
  logic              mux_y;

  assign sel = (state_q == ST_SWEEP) ? cnt_q : bus.in_vec;

  lut_mux #(.SEL_W(N_IN)) u_mux (
    .tt  (tt_q),
    .sel (sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    sig_work_d  = sig_work_q;
    sweep_sig_d = sweep_sig_q;
    cnt_d       = cnt_q;
    sweep_vec_d = sweep_vec_q;
    acc_d       = acc_q;
    ones_d      = ones_q;
    out_d       = mux_y;
    case (state_q)
      ST_IDLE: begin
        // Config wins over a simultaneous start request.
        if (bus.cfg_en) begin
          tt_d = {bus.cfg_bit, tt_q[TT_W-1:1]};
        end else if (bus.sweep_start) begin
          state_d     = ST_SWEEP;
          cnt_d       = '0;
          acc_d       = '0;
          sweep_vec_d = '0;
        end
      end
      ST_SWEEP: begin
        sig_work_d[cnt_q] = mux_y;
        acc_d             = acc_q + {{N_IN{1'b0}}, mux_y};
        cnt_d             = cnt_q + 1'b1;
        // sweep_vec tracks the index being evaluated and freezes on the last one.
        if (cnt_q == LAST) state_d = ST_DONE;
        else               sweep_vec_d = cnt_d;
      end
      ST_DONE: begin
        sweep_sig_d = sig_work_q;
        ones_d      = acc_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SWEEP);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tt_q        <= '0;
      sig_work_q  <= '0;
      sweep_sig_q <= '0;
      cnt_q       <= '0;
      sweep_vec_q <= '0;
      acc_q       <= '0;
      ones_q      <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      sig_work_q  <= sig_work_d;
      sweep_sig_q <= sweep_sig_d;
      cnt_q       <= cnt_d;
      sweep_vec_q <= sweep_vec_d;
      acc_q       <= acc_d;
      ones_q      <= ones_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.sweep_busy = busy_q;
  assign bus.sweep_done = done_q;
  assign bus.sweep_vec  = sweep_vec_q;
  assign bus.sweep_sig  = sweep_sig_q;
  assign bus.ones_cnt   = ones_q;
endmodule

// File: tb/tb_prog_lut_sweep.sv
// Directed bench for prog_lut_sweep: a 4-input and a 3-input instance.
module tb_prog_lut_sweep;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] tt_m;

  always #5 clk = ~clk;

  prog_lut_sweep_if #(.N_IN(4)) b4 ();
  prog_lut_sweep_if #(.N_IN(3)) b3 ();

  prog_lut_sweep #(.N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  prog_lut_sweep #(.N_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      b4.cfg_en = 1'b1; b4.cfg_bit = v[i];
      step();
    end
    b4.cfg_en = 1'b0;
    tt_m = v;
  endtask

  task automatic eval4(input logic [3:0] iv, input logic exp, input string tag);
    b4.in_vec = iv;
    step();
    chk(tag, 32'(b4.out), 32'(exp));
  endtask

  // Start at edge 0; busy for 16 samples; done/results after edge 17.
  task automatic sweep4(input logic [4:0] exp_ones, input bit poke_start);
    b4.sweep_start = 1'b1;
    step();
    b4.sweep_start = 1'b0;
    chk("sw_busy0", 32'(b4.sweep_busy), 32'd1);
    chk("sw_vec0", 32'(b4.sweep_vec), 32'd0);
    for (int k = 1; k < 16; k++) begin
      b4.sweep_start = poke_start && (k == 5);
      step();
      b4.sweep_start = 1'b0;
      chk($sformatf("sw_busy%0d", k), 32'(b4.sweep_busy), 32'd1);
      chk($sformatf("sw_vec%0d", k), 32'(b4.sweep_vec), 32'(k));
      chk($sformatf("sw_out%0d", k - 1), 32'(b4.out), 32'(tt_m[k-1]));
      chk($sformatf("sw_ndone%0d", k), 32'(b4.sweep_done), 32'd0);
    end
    step();
    chk("sw_busy16", 32'(b4.sweep_busy), 32'd0);
    chk("sw_vec16", 32'(b4.sweep_vec), 32'd15);
    chk("sw_out15", 32'(b4.out), 32'(tt_m[15]));
    chk("sw_done16", 32'(b4.sweep_done), 32'd0);
    step();
    chk("sw_done17", 32'(b4.sweep_done), 32'd1);
    chk("sw_sig", 32'(b4.sweep_sig), 32'(tt_m));
    chk("sw_ones", 32'(b4.ones_cnt), 32'(exp_ones));
    step();
    chk("sw_done18", 32'(b4.sweep_done), 32'd0);
    chk("sw_busy18", 32'(b4.sweep_busy), 32'd0);
    chk("sw_sig_hold", 32'(b4.sweep_sig), 32'(tt_m));
  endtask

  initial begin
    rst_n = 1'b0;
    b4.cfg_en = 0; b4.cfg_bit = 0; b4.in_vec = '0; b4.sweep_start = 0;
    b3.cfg_en = 0; b3.cfg_bit = 0; b3.in_vec = '0; b3.sweep_start = 0;
    step(); step();
    chk("rst_out", 32'(b4.out), 32'd0);
    chk("rst_busy", 32'(b4.sweep_busy), 32'd0);
    chk("rst_done", 32'(b4.sweep_done), 32'd0);
    chk("rst_vec", 32'(b4.sweep_vec), 32'd0);
    chk("rst_sig", 32'(b4.sweep_sig), 32'd0);
    chk("rst_ones", 32'(b4.ones_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // 4-input parity
    load4(16'h6996);
    eval4(4'b0000, 1'b0, "par_0000");
    eval4(4'b0001, 1'b1, "par_0001");
    eval4(4'b0011, 1'b0, "par_0011");
    eval4(4'b0111, 1'b1, "par_0111");
    eval4(4'b1111, 1'b0, "par_1111");
    sweep4(5'd8, 1'b0);

    // cfg_en and sweep_start together: shift only, no sweep
    b4.cfg_en = 1'b1; b4.cfg_bit = 1'b1; b4.sweep_start = 1'b1;
    step();
    b4.cfg_en = 1'b0; b4.sweep_start = 1'b0;
    chk("cs_busy", 32'(b4.sweep_busy), 32'd0);
    step();
    chk("cs_busy2", 32'(b4.sweep_busy), 32'd0);
    eval4(4'b1111, 1'b1, "cs_tt15");
    eval4(4'b0000, 1'b1, "cs_tt0");
    eval4(4'b0001, 1'b1, "cs_tt1");
    eval4(4'b0010, 1'b0, "cs_tt2");

    // 4-input AND with a stray start mid-sweep
    load4(16'h8000);
    sweep4(5'd1, 1'b1);

    // all ones: count reaches 16 without wrapping
    load4(16'hFFFF);
    sweep4(5'd16, 1'b0);

    // reset mid-sweep
    load4(16'h6996);
    b4.sweep_start = 1'b1;
    step();
    b4.sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("mr_busy_pre", 32'(b4.sweep_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(b4.sweep_busy), 32'd0);
    chk("mr_vec", 32'(b4.sweep_vec), 32'd0);
    chk("mr_out", 32'(b4.out), 32'd0);
    chk("mr_sig", 32'(b4.sweep_sig), 32'd0);
    chk("mr_ones", 32'(b4.ones_cnt), 32'd0);
    step();
    chk("mr_done", 32'(b4.sweep_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mr_done2", 32'(b4.sweep_done), 32'd0);
    chk("mr_busy2", 32'(b4.sweep_busy), 32'd0);
    load4(16'h6996);
    sweep4(5'd8, 1'b0);

    // 3-input instance: 8-cycle sweep
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v3;
      v3 = 8'h96;
      b3.cfg_en = 1'b1; b3.cfg_bit = v3[i];
      step();
    end
    b3.cfg_en = 1'b0;
    b3.sweep_start = 1'b1;
    step();
    b3.sweep_start = 1'b0;
    chk("n3_busy0", 32'(b3.sweep_busy), 32'd1);
    for (int k = 1; k < 8; k++) step();
    chk("n3_busy7", 32'(b3.sweep_busy), 32'd1);
    chk("n3_vec7", 32'(b3.sweep_vec), 32'd7);
    step();
    chk("n3_busy8", 32'(b3.sweep_busy), 32'd0);
    chk("n3_done8", 32'(b3.sweep_done), 32'd0);
    step();
    chk("n3_done9", 32'(b3.sweep_done), 32'd1);
    chk("n3_sig", 32'(b3.sweep_sig), 32'h96);
    chk("n3_ones", 32'(b3.ones_cnt), 32'd4);
    step();
    chk("n3_done10", 32'(b3.sweep_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
